muldiv_sequencer: RTL

Iterative signed multiply/divide unit with its own sequencing FSM, feeding the HI and LO registers of the multi-cycle MIPS datapath. `control_unit` launches an operation with a one-cycle `start`, holds in its wait state while `busy` is high, and commits results on `done`. Division by zero is reported to `control_unit` via `div_zero` for exception handling. Replaces the separate DIV/MULT blocks and the DivMultCtrl selection feeding HI/LO.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_sequencer_if.sv | 22 ++
 rtl/muldiv_core.sv | 51 +++++
 rtl/muldiv_sequencer.sv | 128 ++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MULT  = 3'd1,
    S_DIV   = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4,
    S_DZERO = 3'd5
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_ITER  = DEF_WIDTH;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Launch/result handshake between control_unit and the multiply/divide unit.
interface muldiv_sequencer_if #(parameter int WIDTH = muldiv_pkg::DEF_WIDTH);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, a_in, b_in,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, a_in, b_in,
    output busy, done, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/muldiv_core.sv
// Shared shift registers for unsigned shift-add multiply and restoring divide.
// hiAcc/loAcc hold {product high, multiplier/product low} for multiply and
// {partial remainder, dividend/quotient} for divide.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clock,
  input  logic             load,
  input  logic             step,
  input  logic             op,
  input  logic [WIDTH-1:0] aMag,
  input  logic [WIDTH-1:0] bMag,
  output logic [WIDTH-1:0] hiAcc,
  output logic [WIDTH-1:0] loAcc
);

  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   divShift;
  logic [WIDTH-1:0] divRem;
  logic             divGe;

  // One iteration of each algorithm, computed from the current register contents
  always_comb begin
    mulSum   = {1'b0, hiAcc} + (loAcc[0] ? {1'b0, operand} : '0);
    divShift = {hiAcc, loAcc[WIDTH-1]};
    divGe    = (divShift >= {1'b0, operand});
    // Partial remainder stays below the divisor, so the difference fits in WIDTH bits
    divRem   = divShift[WIDTH-1:0] - operand;
  end

  // Load magnitudes on launch, then advance one bit per step
  always_ff @(posedge clock) begin
    if (load) begin
      hiAcc   <= '0;
      loAcc   <= (op == OP_DIV) ? aMag : bMag;
      operand <= (op == OP_DIV) ? bMag : aMag;
    end else if (step) begin
      if (op == OP_MULT) begin
        hiAcc <= mulSum[WIDTH:1];
        loAcc <= {mulSum[0], loAcc[WIDTH-1:1]};
      end else begin
        hiAcc <= divGe ? divRem : divShift[WIDTH-1:0];
        loAcc <= {loAcc[WIDTH-2:0], divGe};
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencing FSM for the signed multiply/divide unit feeding HI/LO.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ITER  = DEF_ITER
) (
  input  logic                clock,
  input  logic                reset,
  muldiv_sequencer_if.slave   bus
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic               signA;
  logic               signB;
  logic               opReg;

  logic               coreLoad;
  logic               coreStep;
  logic               coreOp;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic [WIDTH-1:0]   hiAcc;
  logic [WIDTH-1:0]   loAcc;

  logic [2*WIDTH-1:0] prodMag;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH-1:0]   quotFix;
  logic [WIDTH-1:0]   remFix;

  // Unsigned magnitude; the most negative value maps to itself without overflow
  function automatic logic [WIDTH-1:0] absVal(input logic signed [WIDTH-1:0] x);
    return $unsigned(x[WIDTH-1] ? -x : x);
  endfunction

  // Launch decode and operand magnitudes for the datapath
  always_comb begin
    aMag     = absVal(bus.a_in);
    bMag     = absVal(bus.b_in);
    coreLoad = (state == S_IDLE) && bus.start &&
               !((bus.op == OP_DIV) && (bus.b_in == '0));
    coreStep = (state == S_MULT) || (state == S_DIV);
    coreOp   = (state == S_IDLE) ? bus.op : opReg;
  end

  muldiv_core #(.WIDTH(WIDTH)) core (
    .clock (clock),
    .load  (coreLoad),
    .step  (coreStep),
    .op    (coreOp),
    .aMag  (aMag),
    .bMag  (bMag),
    .hiAcc (hiAcc),
    .loAcc (loAcc)
  );

  // Sign correction of the unsigned results; remainder follows the dividend
  always_comb begin
    prodMag = {hiAcc, loAcc};
    prodFix = (signA ^ signB) ? -prodMag : prodMag;
    quotFix = (signA ^ signB) ? -loAcc : loAcc;
    remFix  = signA ? -hiAcc : hiAcc;
  end

  // Control FSM with registered busy/done/div_zero and result registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_IDLE;
      count        <= '0;
      signA        <= 1'b0;
      signB        <= 1'b0;
      opReg        <= OP_MULT;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      bus.hi_out   <= '0;
      bus.lo_out   <= '0;
    end else begin
      bus.done     <= 1'b0;
      bus.div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if ((bus.op == OP_DIV) && (bus.b_in == '0)) begin
              state        <= S_DZERO;
              bus.div_zero <= 1'b1;
            end else begin
              state    <= (bus.op == OP_DIV) ? S_DIV : S_MULT;
              bus.busy <= 1'b1;
              count    <= CNT_W'(ITER - 1);
              signA    <= bus.a_in[WIDTH-1];
              signB    <= bus.b_in[WIDTH-1];
              opReg    <= bus.op;
            end
          end
        end
        S_MULT, S_DIV: begin
          if (count == '0) state <= S_FIX;
          else             count <= count - 1'b1;
        end
        S_FIX: begin
          if (opReg == OP_MULT) begin
            bus.hi_out <= prodFix[2*WIDTH-1:WIDTH];
            bus.lo_out <= prodFix[WIDTH-1:0];
          end else begin
            bus.hi_out <= remFix;
            bus.lo_out <= quotFix;
          end
          state    <= S_DONE;
          bus.done <= 1'b1;
        end
        S_DONE: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
        S_DZERO: state <= S_IDLE;
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
